// File: rtl/caliptra_prim_subreg_pkg.sv
// Shared types for register slices: SW access modes, shadow phase and multi-bit bool codes.
package caliptra_prim_subreg_pkg;

   typedef enum logic [2:0] {
      SwAccessRW  = 3'd0,
      SwAccessRO  = 3'd1,
      SwAccessWO  = 3'd2,
      SwAccessW1C = 3'd3,
      SwAccessW1S = 3'd4,
      SwAccessW0C = 3'd5,
      SwAccessRC  = 3'd6
   } sw_access_e;

   typedef enum logic {
      ShPhaseIdle   = 1'b0,
      ShPhaseStaged = 1'b1
   } shadow_phase_e;

   // 4-bit multi-bit-bool encodings used when merging W1S/W1C nibbles.
   localparam logic [3:0] MuBi4True  = 4'h6;
   localparam logic [3:0] MuBi4False = 4'h9;

endpackage

// File: rtl/caliptra_prim_subreg_arb.sv
// Write arbiter: merges SW write data with the current value according to the access mode.
module caliptra_prim_subreg_arb
   import caliptra_prim_subreg_pkg::*;
#(
   parameter int unsigned DW       = 32,
   parameter sw_access_e  SwAccess = SwAccessRW,
   parameter bit          Mubi     = 1'b0
) (
   input  logic          we,
   input  logic [DW-1:0] wd,
   input  logic          de,
   input  logic [DW-1:0] d,
   input  logic [DW-1:0] q,
   output logic          wr_en,
   output logic [DW-1:0] wr_data
);

   logic [DW-1:0] sw_data;

   // SW data after applying the access-mode merge against the current value.
   always_comb begin
      sw_data = wd;
      case (SwAccess)
         SwAccessW1S: sw_data = q | wd;
         SwAccessW1C: sw_data = q & ~wd;
         SwAccessW0C: sw_data = q & wd;
         default:     sw_data = wd;
      endcase
      // With Mubi, a nibble only changes when SW writes an exact True code to it.
      if (Mubi && (SwAccess == SwAccessW1S || SwAccess == SwAccessW1C)) begin
         for (int unsigned i = 0; i < DW / 4; i++) begin
            if (wd[4*i +: 4] == MuBi4True) begin
               sw_data[4*i +: 4] = (SwAccess == SwAccessW1S) ? MuBi4True : MuBi4False;
            end else begin
               sw_data[4*i +: 4] = q[4*i +: 4];
            end
         end
      end
   end

   // SW has priority over HW when both write in the same cycle.
   assign wr_en   = we | de;
   assign wr_data = we ? sw_data : d;

endmodule

// File: rtl/caliptra_prim_subreg_shadow.sv
// Shadowed register slice: a SW value is committed only after two identical writes.
// Keeps a staged copy, the committed copy and an inverted shadow copy for fault detection.
module caliptra_prim_subreg_shadow
   import caliptra_prim_subreg_pkg::*;
#(
   parameter int unsigned   DW        = 32,
   parameter sw_access_e    SwAccess  = SwAccessRW,
   parameter logic [DW-1:0] RESVAL    = '0,
   parameter bit            Mubi      = 1'b0,
   parameter int unsigned   WrTimeout = 0
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          re,
   input  logic          we,
   input  logic [DW-1:0] wd,
   input  logic          de,
   input  logic [DW-1:0] d,
   output logic          qe,
   output logic [DW-1:0] q,
   output logic [DW-1:0] ds,
   output logic [DW-1:0] qs,
   output logic          phase,
   output logic          err_update,
   output logic          err_timeout,
   output logic          err_storage
);

   if (SwAccess == SwAccessRO || SwAccess == SwAccessRC) begin : gen_bad_access
      $error("caliptra_prim_subreg_shadow: RO/RC access is not supported");
   end
   if (Mubi && (DW % 4 != 0)) begin : gen_bad_mubi
      $error("caliptra_prim_subreg_shadow: Mubi requires DW to be a multiple of 4");
   end

   localparam int unsigned CntW = (WrTimeout > 0) ? $clog2(WrTimeout + 1) : 1;
   localparam logic [CntW-1:0] CntLast = (WrTimeout > 0) ? CntW'(WrTimeout - 1) : '0;

   shadow_phase_e phase_q, phase_d;
   logic [DW-1:0] staged_q, staged_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] committed_q, committed_d;
   logic [DW-1:0] shadow_q, shadow_d;
   logic          err_storage_q, err_storage_d;

   logic          arb_wr_en;
   logic [DW-1:0] arb_wr_data;
   logic          staged_active;
   logic          wd_match;
   logic          sw_commit;

   // SW-only merge path; HW writes are handled separately below.
   caliptra_prim_subreg_arb #(
      .DW       (DW),
      .SwAccess (SwAccess),
      .Mubi     (Mubi)
   ) u_arb (
      .we      (we),
      .wd      (wd),
      .de      (1'b0),
      .d       ({DW{1'b0}}),
      .q       (committed_q),
      .wr_en   (arb_wr_en),
      .wr_data (arb_wr_data)
   );

   assign staged_active = (phase_q == ShPhaseStaged);
   assign wd_match      = (wd == staged_q);
   assign sw_commit     = staged_active && arb_wr_en && wd_match;
   assign err_update    = staged_active && we && !wd_match;
   // A write or read in the expiring cycle takes precedence over the timeout.
   assign err_timeout   = (WrTimeout > 0) && staged_active && !we && !re && (cnt_q == CntLast);

   // Phase FSM, staged copy and timeout counter next-state.
   always_comb begin
      phase_d  = phase_q;
      staged_d = staged_q;
      cnt_d    = cnt_q;
      unique case (phase_q)
         ShPhaseIdle: begin
            if (we) begin
               phase_d  = ShPhaseStaged;
               staged_d = wd;
               cnt_d    = '0;
            end
         end
         ShPhaseStaged: begin
            if (we || re || err_timeout) begin
               phase_d  = ShPhaseIdle;
               staged_d = '0;
               cnt_d    = '0;
            end else if (WrTimeout > 0) begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: phase_d = ShPhaseIdle;
      endcase
   end

   // Committed/shadow next-state; a committing SW write wins over a HW write.
   always_comb begin
      committed_d = committed_q;
      shadow_d    = shadow_q;
      qe          = 1'b0;
      if (sw_commit) begin
         committed_d = arb_wr_data;
         shadow_d    = ~arb_wr_data;
         qe          = 1'b1;
      end else if (de) begin
         committed_d = d;
         shadow_d    = ~d;
         qe          = 1'b1;
      end
      err_storage_d = err_storage_q | (committed_q != ~shadow_q);
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         phase_q       <= ShPhaseIdle;
         staged_q      <= '0;
         cnt_q         <= '0;
         committed_q   <= RESVAL;
         shadow_q      <= ~RESVAL;
         err_storage_q <= 1'b0;
      end else begin
         phase_q       <= phase_d;
         staged_q      <= staged_d;
         cnt_q         <= cnt_d;
         committed_q   <= committed_d;
         shadow_q      <= shadow_d;
         err_storage_q <= err_storage_d;
      end
   end

   assign q           = committed_q;
   assign qs          = committed_q;
   assign ds          = qe ? committed_d : committed_q;
   assign phase       = phase_q;
   assign err_storage = err_storage_q;

endmodule

// File: tb/tb_caliptra_prim_subreg_shadow.sv
// Bench: two slices (RW with timeout, W1C with RESVAL 0xFF) driven by shared stimulus,
// checked per cycle against a transaction-level model through a scoreboard queue.
module tb_caliptra_prim_subreg_shadow;
   import caliptra_prim_subreg_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_i = 1'b1, re = 1'b0, we = 1'b0, de = 1'b0;
   logic [31:0] wd = '0, d = '0;

   logic        qe_a, ph_a, eu_a, et_a, es_a;
   logic [31:0] q_a, ds_a, qs_a;
   logic        qe_b, ph_b, eu_b, et_b, es_b;
   logic [31:0] q_b, ds_b, qs_b;

   caliptra_prim_subreg_shadow #(
      .DW(32), .SwAccess(SwAccessRW), .RESVAL(32'h0), .Mubi(1'b0), .WrTimeout(4)
   ) dut_a (
      .clk_i(clk), .rst_i(rst_i), .re(re), .we(we), .wd(wd), .de(de), .d(d),
      .qe(qe_a), .q(q_a), .ds(ds_a), .qs(qs_a), .phase(ph_a),
      .err_update(eu_a), .err_timeout(et_a), .err_storage(es_a)
   );

   caliptra_prim_subreg_shadow #(
      .DW(32), .SwAccess(SwAccessW1C), .RESVAL(32'hFF), .Mubi(1'b0), .WrTimeout(0)
   ) dut_b (
      .clk_i(clk), .rst_i(rst_i), .re(re), .we(we), .wd(wd), .de(de), .d(d),
      .qe(qe_b), .q(q_b), .ds(ds_b), .qs(qs_b), .phase(ph_b),
      .err_update(eu_b), .err_timeout(et_b), .err_storage(es_b)
   );

   typedef struct packed {
      logic        qe;
      logic [31:0] q;
      logic [31:0] ds;
      logic        ph;
      logic        eu;
      logic        et;
      logic        es;
   } obs_t;

   typedef struct packed {
      obs_t a;
      obs_t b;
   } pair_t;

   // Abstract register state: committed value, pending first write, timer, sticky fault.
   typedef struct {
      logic [31:0] q;
      bit          pending;
      logic [31:0] first;
      int          waited;
      bit          fault;
   } mdl_t;

   pair_t       sb[$];
   mdl_t        ma, mb;
   int          passed = 0;
   int          total = 0;
   bit          forced = 0;
   logic [31:0] fval;

   // One cycle of the reference: returns what the slice shows now and its state afterwards.
   function automatic void predict(input mdl_t m, input bit w1c, input int tmo,
                                   input bit w, input logic [31:0] v, input bit r,
                                   input bit hw, input logic [31:0] hv,
                                   output obs_t o, output mdl_t n);
      bit          confirm;
      logic [31:0] sw_val;
      confirm = w && m.pending && (v == m.first);
      sw_val  = w1c ? (m.q & ~v) : v;
      o.q  = m.q;
      o.ph = m.pending;
      o.es = m.fault;
      o.eu = w && m.pending && (v != m.first);
      o.et = (tmo > 0) && m.pending && !w && !r && (m.waited == tmo - 1);
      o.qe = confirm || hw;
      o.ds = confirm ? sw_val : (hw ? hv : m.q);
      n = m;
      n.q = o.ds;
      if (!m.pending) begin
         if (w) begin
            n.pending = 1;
            n.first   = v;
            n.waited  = 0;
         end
      end else if (w || r || o.et) begin
         n.pending = 0;
      end else begin
         n.waited = m.waited + 1;
      end
   endfunction

   function automatic mdl_t reset_state(input logic [31:0] rv);
      mdl_t m;
      m.q = rv; m.pending = 0; m.first = '0; m.waited = 0; m.fault = 0;
      return m;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   // Monitor: every non-reset cycle has one expectation, popped at the falling edge.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         pair_t e;
         e = sb.pop_front();
         chk("a.qe", 32'(qe_a), 32'(e.a.qe));
         chk("a.q", q_a, e.a.q);
         chk("a.qs", qs_a, e.a.q);
         chk("a.ds", ds_a, e.a.ds);
         chk("a.phase", 32'(ph_a), 32'(e.a.ph));
         chk("a.err_update", 32'(eu_a), 32'(e.a.eu));
         chk("a.err_timeout", 32'(et_a), 32'(e.a.et));
         chk("a.err_storage", 32'(es_a), 32'(e.a.es));
         chk("b.qe", 32'(qe_b), 32'(e.b.qe));
         chk("b.q", q_b, e.b.q);
         chk("b.qs", qs_b, e.b.q);
         chk("b.ds", ds_b, e.b.ds);
         chk("b.phase", 32'(ph_b), 32'(e.b.ph));
         chk("b.err_update", 32'(eu_b), 32'(e.b.eu));
         chk("b.err_timeout", 32'(et_b), 32'(e.b.et));
         chk("b.err_storage", 32'(es_b), 32'(e.b.es));
      end
   end

   // Drive one cycle; inj flips bit 3 of dut_a's shadow copy for one edge.
   task automatic step(input bit r, input bit w, input logic [31:0] v, input bit rd,
                       input bit hw, input logic [31:0] hv, input bit inj);
      obs_t  oa, ob;
      mdl_t  na, nb;
      pair_t p;
      @(posedge clk);
      #1;
      if (forced) begin
         release dut_a.shadow_q;
         forced = 0;
      end
      rst_i = r; we = w; wd = v; re = rd; de = hw; d = hv;
      if (r) begin
         ma = reset_state(32'h0);
         mb = reset_state(32'hFF);
      end else begin
         predict(ma, 1'b0, 4, w, v, rd, hw, hv, oa, na);
         predict(mb, 1'b1, 0, w, v, rd, hw, hv, ob, nb);
         if (inj) begin
            fval = ~ma.q ^ 32'h8;
            force dut_a.shadow_q = fval;
            forced   = 1;
            na.fault = 1;
         end
         p.a = oa;
         p.b = ob;
         sb.push_back(p);
         ma = na;
         mb = nb;
      end
   endtask

   task automatic idle();
      step(0, 0, '0, 0, 0, '0, 0);
   endtask

   task automatic wr(input logic [31:0] v);
      step(0, 1, v, 0, 0, '0, 0);
   endtask

   task automatic rst();
      step(1, 0, '0, 0, 0, '0, 0);
   endtask

   initial begin
      ma = reset_state(32'h0);
      mb = reset_state(32'hFF);
      rst(); rst();
      idle();
      // Double write commits.
      wr(32'hA5A5_0001); wr(32'hA5A5_0001); idle();
      // Mismatch, then a clean pair.
      wr(32'h1234); wr(32'h1235); idle(); wr(32'h7); wr(32'h7); idle();
      // HW write concurrent with a committing SW write.
      rst();
      wr(32'h0F); step(0, 1, 32'h0F, 0, 1, 32'h3C, 0); idle();
      // Staged write abandoned by timeout, then a lone write only stages.
      rst();
      wr(32'h55); idle(); idle(); idle(); idle(); wr(32'h55); idle();
      // Read abandons the stage; reset while staged.
      rst();
      wr(32'h99); step(0, 0, '0, 1, 0, '0, 0); wr(32'h99); idle(); rst(); idle();
      // HW-only write.
      step(0, 0, '0, 0, 1, 32'hDEAD_BEEF, 0); idle();
      // Storage fault is sticky across writes until reset.
      step(0, 0, '0, 0, 0, '0, 1); idle(); idle();
      wr(32'h3); wr(32'h3); idle(); rst(); idle(); idle();
      // Randomized traffic.
      for (int i = 0; i < 500; i++) begin
         bit          r, w, rd, hw;
         logic [31:0] v;
         r  = ($urandom_range(0, 63) == 0);
         w  = ($urandom_range(0, 1) == 1);
         rd = ($urandom_range(0, 5) == 0);
         hw = ($urandom_range(0, 7) == 0);
         v  = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 3));
         step(r, w, v, rd, hw, $urandom(), 0);
      end
      idle();
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      total++;
      if (sb.size() == 0) passed++;
      else $display("FAIL drain: got %0d pending expected 0", sb.size());
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
